// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage, word requests to imem, in-order response FIFO, decode handshake.
// Latency: a response in cycle t is visible to decode in cycle t+1 (registered FIFO, no bypass).
// Backpressure: credits (occ + outstanding < DEPTH) throttle imem_req; decode stalls via if_ready.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request/response
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // pipeline redirect
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // decode interface
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode,
  output logic [2:0]  if_f3,
  output logic        if_f7,
  output logic [24:0] if_immSample
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0]    ST_RUN   = 1'b0;
  localparam logic [0:0]    ST_DRAIN = 1'b1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;
  localparam logic [31:0]   PC_RST   = RESET_PC & 32'hFFFF_FFFC;

  // control state
  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;

  // response buffer (pc + instruction) and its pointers
  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  // in-order tags: address of every accepted request, popped by every response
  logic [31:0]   tag_pc_q [DEPTH];
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;

  logic          in_drain;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   rsp_pc;

  assign in_drain   = (state_q == ST_DRAIN);
  assign credit_sum = {1'b0, occ_q} + {1'b0, out_q};
  assign credit_ok  = (credit_sum < DEPTH_C);

  // A redirect withdraws the request in its own cycle so no stale-path address is accepted.
  assign imem_req  = !rst && !in_drain && !redirect && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_gnt;

  // Responses only enter the buffer while running; drain/redirect responses are dropped.
  assign push   = imem_rvalid && !redirect && !in_drain;
  assign pop    = if_valid && if_ready && !redirect;
  assign rsp_pc = tag_pc_q[tag_rd_q];

  // decode-facing outputs, NOP at pc 0 when the buffer is empty
  assign if_valid     = (occ_q != '0);
  assign if_instr     = if_valid ? buf_instr_q[rd_ptr_q] : NOP;
  assign if_pc        = if_valid ? buf_pc_q[rd_ptr_q]    : 32'h0000_0000;
  assign if_opcode    = if_instr[6:0];
  assign if_f3        = if_instr[14:12];
  assign if_f7        = if_instr[30];
  assign if_immSample = if_instr[31:7];

  // Tag pointers advance on acceptance and on every response, independent of redirects.
  always_comb begin
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (accept) begin
      tag_wr_d = tag_wr_q + PTR_ONE;
    end
    if (imem_rvalid) begin
      tag_rd_d = tag_rd_q + PTR_ONE;
    end
  end

  // Next-state for pc, counters, buffer pointers and the RUN/DRAIN machine.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    disc_d     = disc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_d      = out_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, imem_rvalid};

    if (redirect) begin
      // Everything in flight is now on the wrong path; count what must still come back.
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      disc_d     = out_q - {{(CW-1){1'b0}}, imem_rvalid};
      state_d    = (disc_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_ONE;
        2'b01:   occ_d = occ_q - CNT_ONE;
        default: occ_d = occ_q;
      endcase
      if (in_drain && imem_rvalid) begin
        disc_d = disc_q - CNT_ONE;
        if (disc_d == '0) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= PC_RST;
      occ_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  // Storage arrays carry no reset; occupancy and tag pointers decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= rsp_pc;
      buf_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage for the pipelined RV32I core: the producer side of the decode interface. Issues word requests to instruction memory, buffers in-order responses in a small FIFO, and presents one instruction per cycle to decode under a valid/ready handshake. The instruction is pre-split into the opcode, f3, f7 and immSample fields that decode consumes. Handles pipeline redirects (branch, jump) by flushing the buffer and discarding responses still in flight.

## Interface
Parameters:
- DEPTH, 4, FIFO entries and maximum requests in flight; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address; bits [1:0] always 0.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
- if_valid  out  1  instruction available.
- if_ready  in  1  decode accepts; transfer occurs when if_valid && if_ready.
- if_instr  out  32  instruction word.
- if_pc  out  32  address of if_instr.
- if_opcode  out  7  if_instr[6:0].
- if_f3  out  3  if_instr[14:12].
- if_f7  out  1  if_instr[30].
- if_immSample  out  25  if_instr[31:7].

## Operation
- Registers: fetch_pc; FIFO of DEPTH entries of {pc, instr}; occ counter (0..DEPTH); outstanding counter (0..DEPTH); discard counter; state.
- States: RUN, DRAIN. Reset enters RUN.
- Credit rule: in RUN, imem_req = !redirect && (occ + outstanding < DEPTH). imem_req is never asserted in DRAIN.
- On acceptance: fetch_pc += 4, with 32-bit wrap (0xFFFF_FFFC -> 0). outstanding += 1, and the accepted address is tagged in order.
- Request hold: while imem_req is high and imem_gnt is low, imem_addr is held stable. Only redirect may withdraw the request.
- Response in RUN: the word is written to the FIFO tail with its tagged pc, and outstanding -= 1.
- Response in DRAIN, or in a redirect cycle: the word is dropped. discard -= 1 and outstanding -= 1.
- Credits guarantee the FIFO cannot overflow. An overflowing write is not reachable and must not occur.
- Output: if_valid = (occ != 0).
- if_instr and if_pc come from the FIFO head.
- When the FIFO is empty, if_instr = 32'h0000_0013 (NOP) and if_pc = 0. The field outputs always equal slices of if_instr.
- Transfer: if_valid && if_ready pops the head.
- Simultaneous push and pop leaves occ unchanged.
- Redirect (either state) takes priority over everything else in its cycle:
  - FIFO cleared, occ = 0. Any pop that cycle is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding − (imem_rvalid ? 1 : 0).
  - Next state is DRAIN if that value is non-zero, else RUN.
- DRAIN -> RUN when the last discarded response arrives (discard reaches 0). The first request to the new pc goes out in the following cycle.
- Reset mid-operation: all counters are cleared and the state returns to RUN. Any response arriving after reset is released is outside the protocol; the memory is reset together with this block.

## Timing
- Reset values:
  - imem_req = 0 while rst is asserted, and imem_addr = RESET_PC.
  - if_valid = 0, if_instr = 32'h0000_0013, if_pc = 0, if_opcode = 7'h13, if_f3 = 0, if_f7 = 0, if_immSample = 0.
- First cycle after reset release: imem_req = 1 with imem_addr = RESET_PC.
- Response to decode latency: imem_rvalid in cycle t gives if_valid in cycle t+1. The FIFO is registered, with no bypass.
- Throughput: 1 instruction per cycle, given gnt=1 every cycle, response latency L and DEPTH > L.
- Redirect in cycle t:
  - if_valid = 0 from t+1.
  - With outstanding = 0, imem_req = 1 with imem_addr = redirect_pc at t+1.

## Test plan
- Reset: hold rst with random inputs -> all outputs at the reset values above. After release, first request is to 0x0.
- Streaming: gnt=1, rvalid one cycle after acceptance, ready=1, rdata = addr ^ 0xA5A5_0000 -> if_pc = 0, 4, 8, … delivered on consecutive cycles with matching if_instr, and fields equal the slices of if_instr.
- Backpressure: ready=0 -> exactly DEPTH (4) requests accepted, then imem_req low. After ready=1, the 4 instructions drain in order and requests resume at pc 0x10.
- Grant stall: gnt=0 for 3 cycles -> imem_req stays high and imem_addr is constant. Acceptance occurs on the 4th cycle, and the next address is +4.
- Redirect with 2 outstanding: redirect_pc = 0x103 -> the 2 late responses are dropped, no request is made in DRAIN, the next request goes to 0x100, and the first delivered if_pc = 0x100.
- Redirect coinciding with rvalid and a pop: that response is dropped, outstanding and discard are consistent, and no stale instruction is ever delivered afterwards.
